// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a qualified lock with a
// bounded timeout and retry budget, and reports RUN/FAIL on the reference clock.
module pll_lock_supervisor #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned RST_PULSE     = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       req_reset,
    output logic       pll_rst,
    output logic       ready,
    output logic       fail,
    output logic       lost_lock,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    localparam int unsigned PW = $clog2(RST_PULSE) + 1;
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT) + 1;
    localparam int unsigned SW = $clog2(STABLE_CYCLES) + 1;

    localparam logic [2:0] S_RESET     = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_state;
    logic [PW-1:0]          r_pulse_cnt;
    logic [TW-1:0]          r_timeout_cnt;
    logic [SW-1:0]          r_stable_cnt;
    logic [3:0]             r_retry_cnt;
    logic                   r_pll_rst;
    logic                   r_ready;
    logic                   r_fail;
    logic                   r_lost_lock;

    logic [2:0]             w_state_nxt;
    logic [PW-1:0]          w_pulse_nxt;
    logic [TW-1:0]          w_timeout_nxt;
    logic [SW-1:0]          w_stable_nxt;
    logic [3:0]             w_retry_nxt;
    logic                   w_lost_nxt;
    logic                   w_locked_s;
    logic                   w_timeout_hit;

    assign w_locked_s    = r_sync[SYNC_STAGES-1];
    // This cycle is the last one the lock budget allows.
    assign w_timeout_hit = (r_timeout_cnt == TW'(LOCK_TIMEOUT - 1));

    // Synchronizer chain for the asynchronous locked input.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
        end
    end

    // Next-state, counter and pulse decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_pulse_nxt   = r_pulse_cnt;
        w_timeout_nxt = r_timeout_cnt;
        w_stable_nxt  = r_stable_cnt;
        w_retry_nxt   = r_retry_cnt;
        w_lost_nxt    = 1'b0;

        case (r_state)
            S_RESET: begin
                if (r_pulse_cnt == PW'(RST_PULSE - 1)) begin
                    w_state_nxt   = S_WAIT_LOCK;
                    w_pulse_nxt   = '0;
                    w_timeout_nxt = '0;
                    w_stable_nxt  = '0;
                end else begin
                    w_pulse_nxt = r_pulse_cnt + PW'(1);
                end
            end
            S_WAIT_LOCK, S_STABLE: begin
                if (w_timeout_hit) begin
                    w_timeout_nxt = TW'(LOCK_TIMEOUT);
                    w_stable_nxt  = '0;
                    if (r_retry_cnt < 4'(MAX_RETRIES)) begin
                        w_retry_nxt = r_retry_cnt + 4'd1;
                        w_state_nxt = S_RESET;
                        w_pulse_nxt = '0;
                    end else begin
                        w_state_nxt = S_FAIL;
                    end
                end else begin
                    w_timeout_nxt = r_timeout_cnt + TW'(1);
                    if (r_state == S_WAIT_LOCK) begin
                        if (w_locked_s) begin
                            w_state_nxt  = S_STABLE;
                            w_stable_nxt = SW'(1);
                        end
                    end else if (!w_locked_s) begin
                        // Flapping lock restarts qualification but keeps the timeout running.
                        w_state_nxt  = S_WAIT_LOCK;
                        w_stable_nxt = '0;
                    end else if (r_stable_cnt == SW'(STABLE_CYCLES)) begin
                        w_state_nxt = S_RUN;
                        w_retry_nxt = '0;
                    end else begin
                        w_stable_nxt = r_stable_cnt + SW'(1);
                    end
                end
            end
            S_RUN: begin
                if (!w_locked_s) begin
                    w_lost_nxt  = 1'b1;
                    w_state_nxt = S_RESET;
                    w_pulse_nxt = '0;
                end
            end
            S_FAIL: begin
                w_state_nxt = S_FAIL;
            end
            default: begin
                w_state_nxt = S_RESET;
                w_pulse_nxt = '0;
            end
        endcase

        // Restart request overrides every other transition; lost_lock is kept.
        if (req_reset) begin
            w_state_nxt   = S_RESET;
            w_pulse_nxt   = '0;
            w_timeout_nxt = '0;
            w_stable_nxt  = '0;
            w_retry_nxt   = '0;
        end
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RESET;
            r_pulse_cnt   <= '0;
            r_timeout_cnt <= '0;
            r_stable_cnt  <= '0;
            r_retry_cnt   <= '0;
            r_pll_rst     <= 1'b1;
            r_ready       <= 1'b0;
            r_fail        <= 1'b0;
            r_lost_lock   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pulse_cnt   <= w_pulse_nxt;
            r_timeout_cnt <= w_timeout_nxt;
            r_stable_cnt  <= w_stable_nxt;
            r_retry_cnt   <= w_retry_nxt;
            r_pll_rst     <= (w_state_nxt == S_RESET);
            r_ready       <= (w_state_nxt == S_RUN);
            r_fail        <= (w_state_nxt == S_FAIL);
            r_lost_lock   <= w_lost_nxt;
        end
    end

    assign pll_rst   = r_pll_rst;
    assign ready     = r_ready;
    assign fail      = r_fail;
    assign lost_lock = r_lost_lock;
    assign retry_cnt = r_retry_cnt;
    assign state     = r_state;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sits on the consumer side of a PLL instance; owns that PLL's reset input and watches its locked output.
- Pulses the PLL reset, waits for lock with a timeout, qualifies lock stability, then asserts ready to release downstream reset logic.
- On timeout it retries a bounded number of times, then latches a fail state.
- Runs entirely on the PLL reference clock, so it works while the PLL outputs are dead.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for the asynchronous locked input (min 2).
- RST_PULSE, 16, refclk cycles pll_rst is held high per attempt (min 1).
- LOCK_TIMEOUT, 50000, refclk cycles allowed from end of pll_rst to reaching RUN (1 ms at 50 MHz).
- STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before ready.
- MAX_RETRIES, 3, re-reset attempts after the first before entering FAIL (0..15).

Ports:
- refclk  input  1  PLL reference clock; sole clock.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to refclk upstream.
- locked  input  1  PLL lock indicator; asynchronous to refclk.
- req_reset  input  1  one-cycle request to restart the lock sequence from any state.
- pll_rst  output  1  active-high reset to the PLL.
- ready  output  1  high only in RUN.
- fail  output  1  high only in FAIL.
- lost_lock  output  1  one-cycle pulse when lock drops while in RUN.
- retry_cnt  output  4  attempts consumed since the last RUN or req_reset.
- state  output  3  current state encoding (RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4).

Behaviour:
- rst_n low, asynchronous: state=RESET, pll_rst=1, ready=0, fail=0, lost_lock=0, retry_cnt=0, all counters and synchronizer flops=0.
- Synchronizer: locked_s is locked delayed by SYNC_STAGES flops. All decisions use locked_s only.
- All outputs are registered and decoded from the current state. ready, fail and pll_rst change in the same cycle as state.
- RESET:
  - pll_rst=1 for exactly RST_PULSE cycles.
  - Then go to WAIT_LOCK, clearing timeout_cnt and stable_cnt.
- WAIT_LOCK:
  - pll_rst=0; timeout_cnt increments every cycle.
  - If locked_s=1, go to STABLE with stable_cnt=1.
- STABLE:
  - timeout_cnt keeps incrementing; stable_cnt increments while locked_s=1.
  - locked_s=0: return to WAIT_LOCK with stable_cnt=0. timeout_cnt is NOT cleared, so a flapping lock counts against the timeout.
  - stable_cnt reaches STABLE_CYCLES: go to RUN and clear retry_cnt.
- Timeout, checked in WAIT_LOCK and STABLE when timeout_cnt reaches LOCK_TIMEOUT:
  - retry_cnt < MAX_RETRIES: increment retry_cnt, go to RESET.
  - Otherwise go to FAIL; retry_cnt holds.
  - Timeout has priority over a simultaneous STABLE completion.
- RUN:
  - ready=1.
  - locked_s=0: lost_lock=1 for one cycle, go to RESET (ready=0 from that cycle), retry_cnt stays 0.
- FAIL: fail=1, pll_rst=0. Leaves only on req_reset or rst_n.
- req_reset=1 in any state: next state RESET, retry_cnt=0, fail=0, counters cleared.
  - req_reset has priority over timeout, lock loss and completion.
  - lost_lock still pulses if locked_s falls in RUN in the same cycle.
- req_reset held high keeps the block in RESET with the pulse counter restarting each cycle.
- Counter widths are sized with clog2 of the respective parameter plus 1. No wrap: counters saturate at their compare value.
- rst_n asserted mid-sequence: immediate return to reset values. A new sequence starts on deassertion.

Test Plan:
Bench parameters: SYNC_STAGES=2, RST_PULSE=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Power-up, locked rises 5 cycles into WAIT_LOCK and stays high -> pll_rst high 4 cycles after reset release; state 1→2 two cycles after locked rises; ready=1 eight cycles later; retry_cnt=0.
- locked held low -> 3 pll_rst pulses of 4 cycles each, 20 cycles apart; retry_cnt 0→1→2; then state=4, fail=1, pll_rst=0 stable for 100 cycles.
- locked pulses low for 3 cycles midway through STABLE -> state returns to 1 then 2; stable count restarts; RUN reached only if total time ≤20 cycles, else retry_cnt=1.
- In RUN, locked drops -> lost_lock pulses exactly 1 cycle, ready=0, pll_rst=1 for 4 cycles, sequence reruns to RUN.
- In FAIL, req_reset pulse -> fail=0, retry_cnt=0, state=0 next cycle; with locked high the block reaches RUN.
- rst_n asserted during WAIT_LOCK (timeout_cnt=10) -> all outputs at reset values immediately; after release, the full 20-cycle timeout applies again.
